// File: rtl/reg_fifo_gen.sv
`default_nettype none
// ============================================================================
//  Module   : reg_fifo_gen
//  Brief    : Register-based synchronous FIFO for any depth >= 2. It provides
//             occupancy and free-slot counts, threshold flags, a peak-occupancy
//             watermark and an optional full-bypass push.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_fifo_gen #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int AFULL_TH      = FIFO_DEPTH - 1,
    parameter int AEMPTY_TH     = 1,
    parameter bit FULL_BYPASS   = 1'b0,
    parameter int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     clear,
    output logic [LB_FIFO_DEPTH:0]   count,
    output logic [LB_FIFO_DEPTH:0]   free,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [LB_FIFO_DEPTH:0]   max_count
);

    localparam int c_cnt_w = LB_FIFO_DEPTH + 1;
    localparam int c_last  = FIFO_DEPTH - 1;

    localparam logic [LB_FIFO_DEPTH:0]   c_depth    = c_cnt_w'(FIFO_DEPTH);
    localparam logic [LB_FIFO_DEPTH:0]   c_afull    = c_cnt_w'(AFULL_TH);
    localparam logic [LB_FIFO_DEPTH:0]   c_aempty   = c_cnt_w'(AEMPTY_TH);
    localparam logic [LB_FIFO_DEPTH-1:0] c_ptr_last = LB_FIFO_DEPTH'(c_last);

    generate
        if (FIFO_DEPTH < 2) begin : g_bad_depth
            $error("reg_fifo_gen: FIFO_DEPTH must be at least 2");
        end
        if ((AFULL_TH < 1) || (AFULL_TH > FIFO_DEPTH)) begin : g_bad_afull
            $error("reg_fifo_gen: AFULL_TH must lie in 1..FIFO_DEPTH");
        end
        if ((AEMPTY_TH < 0) || (AEMPTY_TH > FIFO_DEPTH - 1)) begin : g_bad_aempty
            $error("reg_fifo_gen: AEMPTY_TH must lie in 0..FIFO_DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [LB_FIFO_DEPTH-1:0] waddr_q, waddr_d;
    logic [LB_FIFO_DEPTH-1:0] raddr_q, raddr_d;
    logic [LB_FIFO_DEPTH:0]   count_q, count_d;
    logic [LB_FIFO_DEPTH:0]   max_count_q, max_count_d;

    logic w_push;
    logic w_pop;
    logic w_in_ready;

    // Wrap explicitly so non-power-of-two depths never index past the last slot.
    function automatic logic [LB_FIFO_DEPTH-1:0] ptr_inc(input logic [LB_FIFO_DEPTH-1:0] p);
        return (p == c_ptr_last) ? '0 : p + LB_FIFO_DEPTH'(1);
    endfunction

    always_comb begin
        w_in_ready = (count_q < c_depth) ||
                     (FULL_BYPASS && (count_q == c_depth) && out_ready);
        w_push     = in_valid && w_in_ready;
        w_pop      = (count_q != '0) && out_ready;
    end

    always_comb begin
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        count_d     = count_q;
        max_count_d = max_count_q;
        if (w_push) begin
            waddr_d = ptr_inc(waddr_q);
        end
        if (w_pop) begin
            raddr_d = ptr_inc(raddr_q);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (w_pop && !w_push) begin
            count_d = count_q - c_cnt_w'(1);
        end
        if (count_d > max_count_q) begin
            max_count_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            waddr_q     <= '0;
            raddr_q     <= '0;
            count_q     <= '0;
            max_count_q <= '0;
        end else begin
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            count_q     <= count_d;
            max_count_q <= max_count_d;
        end
    end

    // Storage is not reset; a flush only needs the pointers and count cleared.
    always_ff @(posedge clk) begin
        if (w_push && !(rst || clear)) begin
            mem_q[waddr_q] <= in_data;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = (count_q != '0);
    assign out_data     = mem_q[raddr_q];
    assign count        = count_q;
    assign free         = c_depth - count_q;
    assign almost_full  = (count_q >= c_afull);
    assign almost_empty = (count_q <= c_aempty);
    assign max_count    = max_count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_fifo_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_fifo_gen
//  Brief    : Directed bench for reg_fifo_gen. It drives two depth-5 instances
//             from shared stimulus: A has FULL_BYPASS=0 and AFULL_TH=3, and
//             B has FULL_BYPASS=1 with the default thresholds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_fifo_gen;

    logic       clk = 1'b0;
    logic       rst, clear;
    logic [7:0] in_data;
    logic       in_valid, out_ready;

    logic       a_in_ready, a_out_valid, a_af, a_ae;
    logic [7:0] a_out_data;
    logic [3:0] a_count, a_free, a_max;
    logic       b_in_ready, b_out_valid, b_af, b_ae;
    logic [7:0] b_out_data;
    logic [3:0] b_count, b_free, b_max;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_fifo_gen #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AFULL_TH(3), .AEMPTY_TH(1),
                   .FULL_BYPASS(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .clear(clear), .count(a_count), .free(a_free),
        .almost_full(a_af), .almost_empty(a_ae), .max_count(a_max)
    );

    reg_fifo_gen #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FULL_BYPASS(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .clear(clear), .count(b_count), .free(b_free),
        .almost_full(b_af), .almost_empty(b_ae), .max_count(b_max)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int exp_idx;
        int nxt;
        int cnt;

        // Reset state
        do_reset();
        check("rst_count", a_count, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_free", a_free, 5);
        check("rst_aempty", a_ae, 1);
        check("rst_afull", a_af, 0);
        check("rst_max", a_max, 0);
        check("rst_b_in_ready", b_in_ready, 1);

        // Fill with 0x10..0x14 while the consumer stalls
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("full_count", a_count, 5);
        check("full_in_ready", a_in_ready, 0);
        check("full_b_in_ready", b_in_ready, 0);
        check("full_afull", a_af, 1);
        check("full_b_afull", b_af, 1);
        check("full_free", a_free, 0);
        check("full_max", a_max, 5);
        check("full_head", a_out_data, 8'h10);

        // Full with push and pop together: only B accepts the push
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        #1;
        check("byp_a_in_ready", a_in_ready, 0);
        check("byp_b_in_ready", b_in_ready, 1);
        check("byp_b_head", b_out_data, 8'h10);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("byp_a_count", a_count, 4);
        check("byp_b_count", b_count, 5);

        // Drain both: A yields 0x11..0x14, B yields 0x11..0x14 then 0x55
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k < 4) begin
                check("drain_a_valid", a_out_valid, 1);
                check("drain_a_data", a_out_data, 8'h11 + k);
                check("drain_b_data", b_out_data, 8'h11 + k);
            end else begin
                check("drain_a_empty", a_out_valid, 0);
                check("drain_b_valid", b_out_valid, 1);
                check("drain_b_data", b_out_data, 8'h55);
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        check("drain_b_empty", b_out_valid, 0);
        check("drain_a_count", a_count, 0);
        check("drain_b_count", b_count, 0);
        check("drain_max_kept", a_max, 5);

        // Push into an empty FIFO while the consumer is ready: no pass-through
        do_reset();
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        out_ready = 1'b1;
        #1;
        check("empty_same_cycle_valid", a_out_valid, 0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("empty_next_valid", a_out_valid, 1);
        check("empty_next_data", a_out_data, 8'h3C);
        check("empty_next_count", a_count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("empty_popped", a_count, 0);

        // Interleaved traffic wraps the depth-5 pointers several times
        exp_idx = 0;
        nxt     = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid  = (nxt < 12);
            in_data   = 8'(nxt);
            out_ready = (cyc >= 2);
            #1;
            if (out_ready && a_out_valid) begin
                check("wrap_a_data", a_out_data, exp_idx);
                check("wrap_b_data", b_out_data, exp_idx);
                exp_idx++;
            end
            @(posedge clk);
            if (in_valid) nxt++;
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("wrap_popped_total", exp_idx, 12);
        check("wrap_count", a_count, 0);
        check("wrap_max", a_max, 2);

        // Threshold flags while stepping occupancy 0 -> 4 -> 0
        do_reset();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            check("th_up_count", a_count, cnt);
            check("th_up_free", a_free, 5 - cnt);
            check("th_up_afull", a_af, (cnt >= 3) ? 1 : 0);
            check("th_up_aempty", a_ae, (cnt <= 1) ? 1 : 0);
            if (i < 4) begin
                in_valid = 1'b1;
                in_data  = 8'(i);
                tick();
                in_valid = 1'b0;
                cnt++;
                #1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            cnt--;
            #1;
            check("th_dn_count", a_count, cnt);
            check("th_dn_afull", a_af, (cnt >= 3) ? 1 : 0);
            check("th_dn_aempty", a_ae, (cnt <= 1) ? 1 : 0);
        end

        // Clear at count 3 while a push and a pop are both handshaked
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h01 + i);
            tick();
        end
        in_data   = 8'h77;
        out_ready = 1'b1;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("clr_count", a_count, 0);
        check("clr_max", a_max, 0);
        check("clr_out_valid", a_out_valid, 0);
        check("clr_in_ready", a_in_ready, 1);
        check("clr_free", a_free, 5);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        in_data  = 8'hBB;
        tick();
        in_valid = 1'b0;
        #1;
        check("clr_first_valid", a_out_valid, 1);
        check("clr_first_data", a_out_data, 8'hAA);
        check("clr_after_count", a_count, 2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("clr_second_data", a_out_data, 8'hBB);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
